calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Sequences one calculator operation over the shared combinational arithmetic datapath (adder/subtractor units producing four BCD digits plus a negative flag).
- Collects two 2-digit BCD operands from keypad pulses, then latches an operation code.
- On "equals", drives the operands to the datapath, waits a fixed settle time, captures the result into a display register and holds it until cleared.
- Sits between the keypad debouncer and the 4-digit display driver.

Parameters:
SETTLE_CYC, 2, cycles operands are held stable before the datapath outputs are sampled (minimum 1).
OP_W, 2, width of operation code.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse: key_digit is valid
key_digit  in  4  BCD digit from keypad
op_valid  in  1  one-cycle pulse: op_code is valid
op_code  in  OP_W  operation (0 add, 1 sub, others reserved)
eq_pulse  in  1  one-cycle "equals" request
clr_pulse  in  1  one-cycle clear request
dp_i1, dp_i2, dp_i3, dp_i4  out  4 each  operand digits to datapath (A tens, A units, B tens, B units)
dp_op  out  OP_W  operation select to datapath
dp_D1, dp_D2, dp_D3, dp_D4  in  4 each  datapath result digits
dp_neg  in  1  datapath negative flag
disp_D1, disp_D2, disp_D3, disp_D4  out  4 each  digits to display
disp_neg  out  1  minus-sign enable
busy  out  1  high in EXEC
done  out  1  one-cycle pulse when the result is captured
err  out  1  sticky: reserved op_code or out-of-range digit seen

Behaviour:
- Reset (async, rst_n low):
  - State = ENTER_A.
  - All dp_* outputs, disp_* outputs, disp_neg, busy, done, err = 0; settle counter = 0.
- States: ENTER_A, ENTER_B, EXEC, SHOW.
- Digit entry, in ENTER_A or ENTER_B, on key_valid with key_digit <= 9:
  - Current operand shifts left one digit: tens <= units, units <= key_digit.
  - Per-operand digit count saturates at 2; a 3rd and later digit is ignored (operand unchanged).
  - key_digit > 9 is ignored and sets err.
- ENTER_A -> ENTER_B on op_valid:
  - op_code is latched into dp_op; operand B is zeroed.
  - Reserved op_code sets err, is still latched, and the state still advances.
- In ENTER_B, a later op_valid overwrites dp_op; the state does not change.
- op_valid in any other state is ignored.
- ENTER_B -> EXEC on eq_pulse, taken even if 0 B digits were entered (B = 00).
- eq_pulse in ENTER_A is ignored.
- EXEC:
  - busy = 1; dp_i* and dp_op are frozen.
  - Counter counts SETTLE_CYC cycles.
  - In the last counted cycle, dp_D1..dp_D4 and dp_neg are registered into disp_D*/disp_neg, done pulses for 1 cycle, next state = SHOW.
  - Latency from eq_pulse to done = SETTLE_CYC + 1 clocks.
- Key, op and eq inputs during EXEC are ignored.
- SHOW: display register held.
  - key_valid starts a new calculation: state = ENTER_A, operand A = 0 then shifted with this digit (count = 1); the display is unchanged until the next done.
  - op_valid in SHOW is ignored.
- clr_pulse in any state, including EXEC:
  - Next cycle: state = ENTER_A; operands, dp_op, disp_* and counter = 0; err cleared; busy = 0; no done pulse.
  - clr takes priority over every simultaneous input.
- Simultaneous key_valid and op_valid in ENTER_A: the digit is applied to A first, then the op is latched and the state advances.
- Simultaneous op_valid and eq_pulse in ENTER_B: the op is latched and EXEC is entered the same edge.
- dp_i* always reflect the registered operands: A in i1/i2, B in i3/i4.
- The datapath is purely combinational; the sequencer never samples dp_D* outside EXEC.

Test Plan:
- Subtraction: rst_n release; keys 4,2; op 1; keys 1,7; eq -> dp_i = 4,2,1,7; done after SETTLE_CYC+1 clocks; disp = 0,0,2,5; disp_neg = 0; state SHOW.
- Negative result: keys 0,9; op 1; keys 3,0; eq -> disp = 0,0,2,1 with disp_neg = 1 (sampled from dp_neg).
- Digit overflow and invalid keys: keys 1,2,3 for A -> A = 12; key 12 -> ignored, err = 1; op 0; eq with no B digits -> B = 00, result 0,0,1,2.
- Clear during EXEC: SETTLE_CYC = 4; clr 2 cycles after eq -> no done, disp all 0, busy = 0, state ENTER_A, err = 0.
- Async reset mid-SHOW: drop rst_n between clock edges -> all outputs 0 immediately, not at the next clock.
- Restart from SHOW: key 5 -> state ENTER_A, A = 05, disp still shows the old result until the next done; eq and op pulses during EXEC have no effect.

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator sequencer: gathers two 2-digit BCD operands and an op from the keypad,
// drives the combinational BCD datapath, waits SETTLE_CYC cycles, then latches the result for display.
module calc_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int OP_W       = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_valid,
  input  logic [3:0]      key_digit,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op_code,
  input  logic            eq_pulse,
  input  logic            clr_pulse,
  output logic [3:0]      dp_i1,
  output logic [3:0]      dp_i2,
  output logic [3:0]      dp_i3,
  output logic [3:0]      dp_i4,
  output logic [OP_W-1:0] dp_op,
  input  logic [3:0]      dp_D1,
  input  logic [3:0]      dp_D2,
  input  logic [3:0]      dp_D3,
  input  logic [3:0]      dp_D4,
  input  logic            dp_neg,
  output logic [3:0]      disp_D1,
  output logic [3:0]      disp_D2,
  output logic [3:0]      disp_D3,
  output logic [3:0]      disp_D4,
  output logic            disp_neg,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, SHOW} state_t;

  state_t            state_q, state_d;
  logic [3:0]        a_hi_q, a_hi_d, a_lo_q, a_lo_d;
  logic [3:0]        b_hi_q, b_hi_d, b_lo_q, b_lo_d;
  logic [1:0]        a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [3:0]        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic key_ok;
  logic op_rsv;

  assign key_ok = (key_digit <= 4'd9);
  assign op_rsv = (32'(op_code) > 32'd1);

  always_comb begin
    state_d = state_q;
    a_hi_d  = a_hi_q;
    a_lo_d  = a_lo_q;
    b_hi_d  = b_hi_q;
    b_lo_d  = b_lo_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    op_d    = op_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    d4_d    = d4_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (clr_pulse) begin
      state_d = ENTER_A;
      a_hi_d  = '0;
      a_lo_d  = '0;
      b_hi_d  = '0;
      b_lo_d  = '0;
      a_cnt_d = '0;
      b_cnt_d = '0;
      op_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      d3_d    = '0;
      d4_d    = '0;
      neg_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (key_valid) begin
            if (!key_ok) begin
              err_d = 1'b1;
            end else if (a_cnt_q != 2'd2) begin
              a_hi_d  = a_lo_q;
              a_lo_d  = key_digit;
              a_cnt_d = a_cnt_q + 2'd1;
            end
          end
          // A digit arriving with the op still lands in A before the op advances the state.
          if (op_valid) begin
            op_d    = op_code;
            err_d   = err_d | op_rsv;
            b_hi_d  = '0;
            b_lo_d  = '0;
            b_cnt_d = '0;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_valid) begin
            if (!key_ok) begin
              err_d = 1'b1;
            end else if (b_cnt_q != 2'd2) begin
              b_hi_d  = b_lo_q;
              b_lo_d  = key_digit;
              b_cnt_d = b_cnt_q + 2'd1;
            end
          end
          if (op_valid) begin
            op_d  = op_code;
            err_d = err_d | op_rsv;
          end
          if (eq_pulse) begin
            cnt_d   = '0;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == CNT_LAST) begin
            d1_d    = dp_D1;
            d2_d    = dp_D2;
            d3_d    = dp_D3;
            d4_d    = dp_D4;
            neg_d   = dp_neg;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (key_valid) begin
            if (!key_ok) begin
              err_d = 1'b1;
            end else begin
              a_hi_d  = '0;
              a_lo_d  = key_digit;
              a_cnt_d = 2'd1;
              state_d = ENTER_A;
            end
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_hi_q  <= '0;
      a_lo_q  <= '0;
      b_hi_q  <= '0;
      b_lo_q  <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      op_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_hi_q  <= a_hi_d;
      a_lo_q  <= a_lo_d;
      b_hi_q  <= b_hi_d;
      b_lo_q  <= b_lo_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      op_q    <= op_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dp_i1    = a_hi_q;
  assign dp_i2    = a_lo_q;
  assign dp_i3    = b_hi_q;
  assign dp_i4    = b_lo_q;
  assign dp_op    = op_q;
  assign disp_D1  = d1_q;
  assign disp_D2  = d2_q;
  assign disp_D3  = d3_q;
  assign disp_D4  = d4_q;
  assign disp_neg = neg_q;
  assign busy     = (state_q == EXEC);
  assign done     = done_q;
  assign err      = err_q;

endmodule
